product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter NTERMS, default 8, number of 8x8 products summed per result (2..255).
REQ-002 Parameter ACC_W, default 19, accumulator width in bits (16..32).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 clr  input  1  synchronous abort; discards the partial sum and pipeline.
REQ-006 in_valid  input  1  operand pair a/b is valid.
REQ-007 in_ready  output  1  block accepts a/b this cycle.
REQ-008 a  input  8  unsigned multiplicand.
REQ-009 b  input  8  unsigned multiplier.
REQ-010 out_valid  output  1  acc_out holds a completed sum.
REQ-011 out_ready  input  1  consumer takes acc_out this cycle.
REQ-012 acc_out  output  ACC_W  unsigned sum of NTERMS products.
REQ-013 ovf  output  1  sticky overflow flag for the current result.

Function
REQ-014 Transfer on a port occurs only in a cycle where valid and ready are both high.
REQ-015 Accepted a/b are registered (stage S1); the 16-bit unsigned product of the registered operands is registered with a valid bit (stage S2).
REQ-016 Each valid S2 product is added to the accumulator on the next edge; the add is zero-extended to ACC_W.
REQ-017 A term counter (0..NTERMS-1) increments per accepted pair and wraps to 0 on the NTERMS-th pair.
REQ-018 FSM states: ACCUM (in_ready=1, collecting), DRAIN (in_ready=0, last pair in pipeline), HOLD (out_valid=1, in_ready=0).
REQ-019 ACCUM->DRAIN on acceptance of the NTERMS-th pair; DRAIN->HOLD when the last product has been added; HOLD->ACCUM on out_valid&&out_ready.
REQ-020 out_valid rises 3 edges after the edge accepting the last pair; in_ready is low from the edge after that acceptance until the edge after the HOLD handshake.
REQ-021 On the HOLD handshake the accumulator, ovf and counter clear to 0; the next pair is accepted no earlier than the following cycle.
REQ-022 acc_out and ovf remain stable while out_valid=1 and out_ready=0.
REQ-023 Back-to-back pairs (in_valid held high) are accepted one per cycle in ACCUM with no bubbles.
REQ-024 clr has priority over every other event: next state ACCUM, accumulator/ovf/counter/S1/S2 valids cleared, a pending result dropped.
REQ-025 in_valid in DRAIN or HOLD is ignored; a/b are not captured.

Reset
REQ-026 While rst=1: state ACCUM, accumulator 0, counter 0, S1/S2 valids 0, ovf 0, out_valid 0, in_ready 0.
REQ-027 in_ready rises on the first clock edge after rst deasserts; reset mid-sum discards all partial data.

Configuration
REQ-028 With ACC_SAT_EN defined, an add whose true sum exceeds 2^ACC_W-1 loads all-ones, sets ovf, and further adds keep all-ones until the result is consumed.
REQ-029 Without ACC_SAT_EN, adds wrap modulo 2^ACC_W, ovf is still set on carry-out, and acc_out holds the wrapped value.

Structure
REQ-030 A shared package holds the FSM state enum, default NTERMS/ACC_W constants, and PROD_W=16.
REQ-031 The 8x8 unsigned multiply is one sub-module instance, EightBitArrayMultiplier, fed from S1 registers; no other sub-modules.

Verification
REQ-032 NTERMS=8, eight pairs a=b=255 back-to-back -> acc_out=520200, ovf=0, out_valid 3 edges after the last acceptance.
REQ-033 NTERMS=4, pairs (3,5),(0,200),(17,1),(255,2) -> acc_out=542, ovf=0.
REQ-034 out_ready held low 10 cycles in HOLD -> acc_out stable, in_ready=0, in_valid stimulus not captured; after handshake the next sum starts from 0.
REQ-035 ACC_W=16, NTERMS=2, pairs (255,255),(255,255) -> ACC_SAT_EN: acc_out=65535, ovf=1; without: acc_out=64514, ovf=1.
REQ-036 clr asserted after 3 of 8 pairs, then 8 pairs of (1,1) -> acc_out=8.
REQ-037 rst pulsed asynchronously mid-sum between edges -> all outputs 0 immediately; the following 8 pairs of (2,3) give acc_out=48.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared FSM state type and default sizing constants.
package product_accumulator_pkg;
   typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;
   localparam int NTERMS_DEF = 8;
   localparam int ACC_W_DEF = 19;
   localparam int PROD_W = 16;
endpackage

// File: rtl/product_accumulator_mult.sv
// product_accumulator_mult: EightBitArrayMultiplier, unsigned 8x8 array multiplier.
module EightBitArrayMultiplier
   import product_accumulator_pkg::*;
(
   input  logic [7:0]        a_i,
   input  logic [7:0]        b_i,
   output logic [PROD_W-1:0] p_o
);
   logic [PROD_W-1:0] row [0:8];
   assign row[0] = '0;
   for (genvar i = 0; i < 8; i++) begin : g_row
      assign row[i+1] = row[i] + (PROD_W'(a_i & {8{b_i[i]}}) << i);
   end
   assign p_o = row[8];
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums NTERMS unsigned 8x8 products through a 2-stage pipeline.
// Define ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int NTERMS = NTERMS_DEF,
   parameter int ACC_W  = ACC_W_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       a,
   input  logic [7:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             ovf
);
   localparam int SW = ACC_W + 1;
   state_t            state_q;
   logic              s1_v_q, s2_v_q, ovf_q, ovf_d, in_ready_q, out_valid_q;
   logic [7:0]        a_q, b_q, cnt_q;
   logic [PROD_W-1:0] prod, prod_q;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [ACC_W:0]    sum;
   logic              take, last, hs;
   EightBitArrayMultiplier u_mul (.a_i(a_q), .b_i(b_q), .p_o(prod));
   assign take = in_valid && in_ready_q;
   assign last = cnt_q == 8'(NTERMS - 1);
   assign hs   = out_valid_q && out_ready;
   assign sum  = {1'b0, acc_q} + SW'(prod_q);
`ifdef ACC_SAT_EN
   assign acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
   assign acc_d = sum[ACC_W-1:0];
`endif
   assign ovf_d = ovf_q | sum[ACC_W];
   // HOLD is entered one edge after the final add, once both pipeline stages are empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ACCUM;
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (clr) begin
         state_q     <= ACCUM;
         s1_v_q      <= 1'b0;
         s2_v_q      <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         s1_v_q <= take;
         s2_v_q <= s1_v_q;
         if (take) begin
            a_q   <= a;
            b_q   <= b;
            cnt_q <= last ? '0 : cnt_q + 8'd1;
         end
         if (s1_v_q) prod_q <= prod;
         if (s2_v_q) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
         end
         case (state_q)
            ACCUM: begin
               in_ready_q <= !(take && last);
               if (take && last) state_q <= DRAIN;
            end
            DRAIN: if (!s1_v_q && !s2_v_q) begin
               state_q     <= HOLD;
               out_valid_q <= 1'b1;
            end
            HOLD: if (hs) begin
               state_q     <= ACCUM;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               acc_q       <= '0;
               ovf_q       <= 1'b0;
               cnt_q       <= '0;
            end
            default: state_q <= ACCUM;
         endcase
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vector table plus corner sequences over three configurations.
module tb_product_accumulator;
   logic clk = 1'b0, rst = 1'b1;
   logic clr [3], iv [3], ordy [3], inr [3], ov [3], of [3];
   logic [7:0] a [3], b [3];
   logic [18:0] acc0, acc1;
   logic [15:0] acc2;
   logic [31:0] accx [3];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   product_accumulator u0 (.clk(clk), .rst(rst), .clr(clr[0]), .in_valid(iv[0]), .in_ready(inr[0]),
      .a(a[0]), .b(b[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .acc_out(acc0), .ovf(of[0]));
   product_accumulator #(.NTERMS(4)) u1 (.clk(clk), .rst(rst), .clr(clr[1]), .in_valid(iv[1]), .in_ready(inr[1]),
      .a(a[1]), .b(b[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .acc_out(acc1), .ovf(of[1]));
   product_accumulator #(.NTERMS(2), .ACC_W(16)) u2 (.clk(clk), .rst(rst), .clr(clr[2]), .in_valid(iv[2]), .in_ready(inr[2]),
      .a(a[2]), .b(b[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .acc_out(acc2), .ovf(of[2]));
   assign accx[0] = 32'(acc0);
   assign accx[1] = 32'(acc1);
   assign accx[2] = 32'(acc2);
   typedef struct {
      int k;
      int n;
      logic [7:0][7:0] av;
      logic [7:0][7:0] bv;
      int unsigned acc;
      bit ovf;
   } vec_t;
   vec_t v [5];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask
   task automatic burst(input int k, input int n, input logic [7:0][7:0] av, input logic [7:0][7:0] bv);
      int w;
      for (int i = 0; i < n; i++) begin
         a[k] = av[i];
         b[k] = bv[i];
         iv[k] = 1'b1;
         w = 0;
         while (!inr[k] && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (w == 20) chk("burst_ready_timeout", 32'(inr[k]), 32'd1);
         @(negedge clk);
      end
      iv[k] = 1'b0;
   endtask
   task automatic finish(input int k, input string nm, input int unsigned ea, input bit eo);
      int w = 0;
      while (!ov[k] && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({nm, "_out_valid"}, 32'(ov[k]), 32'd1);
      chk({nm, "_acc"}, accx[k], ea);
      chk({nm, "_ovf"}, 32'(of[k]), 32'(eo));
      chk({nm, "_hold_ready"}, 32'(inr[k]), 32'd0);
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      chk({nm, "_ov_clr"}, 32'(ov[k]), 32'd0);
      chk({nm, "_ready_back"}, 32'(inr[k]), 32'd1);
      chk({nm, "_acc_clr"}, accx[k], 32'd0);
   endtask
   function automatic vec_t mkv(int k, int n, logic [7:0][7:0] av, logic [7:0][7:0] bv, int unsigned acc, bit o);
      vec_t r;
      r.k = k; r.n = n; r.av = av; r.bv = bv; r.acc = acc; r.ovf = o;
      return r;
   endfunction
   initial begin
      logic [7:0][7:0] ones, p, q;
      logic [31:0] held;
      ones = {8{8'd1}};
      v[0] = mkv(0, 8, {8{8'd255}}, {8{8'd255}}, 520200, 1'b0);
      v[1] = mkv(1, 4, {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd17, 8'd0, 8'd3},
                       {8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd200, 8'd5}, 542, 1'b0);
`ifdef ACC_SAT_EN
      v[2] = mkv(2, 2, {8{8'd255}}, {8{8'd255}}, 65535, 1'b1);
`else
      v[2] = mkv(2, 2, {8{8'd255}}, {8{8'd255}}, 64514, 1'b1);
`endif
      v[3] = mkv(0, 8, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, {8{8'd10}}, 360, 1'b0);
      v[4] = mkv(1, 4, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd200, 8'd100},
                       {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd50, 8'd100}, 20001, 1'b0);
      for (int k = 0; k < 3; k++) begin
         clr[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; a[k] = '0; b[k] = '0;
      end
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", 32'(inr[k]), 32'd0);
         chk("rst_ov", 32'(ov[k]), 32'd0);
         chk("rst_acc", accx[k], 32'd0);
         chk("rst_ovf", 32'(of[k]), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("rst_release_ready", 32'(inr[k]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         burst(v[i].k, v[i].n, v[i].av, v[i].bv);
         chk($sformatf("v%0d_drain_ready", i), 32'(inr[v[i].k]), 32'd0);
         @(negedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_ov_early", i), 32'(ov[v[i].k]), 32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_ov_lat3", i), 32'(ov[v[i].k]), 32'd1);
         finish(v[i].k, $sformatf("v%0d", i), v[i].acc, v[i].ovf);
      end
      // stalled consumer: result must stay put and new pairs must be refused
      p = {8{8'd1}};
      q = {8{8'd2}};
      burst(0, 8, p, q);
      repeat (3) @(negedge clk);
      held = accx[0];
      chk("hold_acc", held, 32'd16);
      a[0] = 8'd99; b[0] = 8'd99; iv[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_stable_acc", accx[0], 32'd16);
         chk("hold_stable_ready", 32'(inr[0]), 32'd0);
      end
      iv[0] = 1'b0;
      finish(0, "hold", 16, 1'b0);
      burst(0, 8, ones, ones);
      finish(0, "after_hold", 8, 1'b0);
      p = {8{8'd50}};
      burst(0, 3, p, p);
      clr[0] = 1'b1;
      @(negedge clk);
      clr[0] = 1'b0;
      chk("clr_acc", accx[0], 32'd0);
      chk("clr_ready", 32'(inr[0]), 32'd1);
      burst(0, 8, ones, ones);
      finish(0, "clr", 8, 1'b0);
      p = {8{8'd9}};
      burst(0, 3, p, p);
      #2 rst = 1'b1;
      #1;
      chk("arst_acc", accx[0], 32'd0);
      chk("arst_ov", 32'(ov[0]), 32'd0);
      chk("arst_ready", 32'(inr[0]), 32'd0);
      chk("arst_ovf", 32'(of[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("arst_ready_low", 32'(inr[0]), 32'd0);
      @(negedge clk);
      chk("arst_ready_up", 32'(inr[0]), 32'd1);
      p = {8{8'd2}};
      q = {8{8'd3}};
      burst(0, 8, p, q);
      finish(0, "arst", 48, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
